// File: rtl/wavetable_loader.sv
// wavetable_loader: write-side companion of the waveform playback oscillator.
// Accepts a valid/ready byte stream and packs each group of RAM_WIDTH/8 bytes,
// MSB first, into one sample. It then writes that sample through port A of the
// waveform RAM, one address after another, from 0 to RAM_DEPTH-1.
//
// Optional build macro: WAVETABLE_LOADER_CHECKSUM_EN
//   When defined, the loader keeps a running XOR of every data byte.
//   After the last sample it enters a CHECK state and consumes one more byte,
//   which it compares with that XOR. A mismatch raises error_out, which stays
//   set until the next start_in.
//   When undefined, there is no CHECK state and error_out is tied to 0.
//
// RAM_WIDTH must be a multiple of 8.

module wavetable_loader #(
   parameter int RAM_WIDTH = 24,
   parameter int RAM_DEPTH = 512
) (
   input  logic                         clk_in,
   input  logic                         rst_in,
   input  logic                         start_in,
   input  logic                         abort_in,
   input  logic [7:0]                   byte_in,
   input  logic                         byte_valid_in,
   output logic                         byte_ready_out,
   output logic [$clog2(RAM_DEPTH)-1:0] wr_addr_out,
   output logic [RAM_WIDTH-1:0]         wr_data_out,
   output logic                         wr_en_out,
   output logic                         busy_out,
   output logic                         done_out,
   output logic                         error_out
);

   // Derived sizes. BYTES_PER_SAMPLE always follows RAM_WIDTH.
   localparam int BYTES_PER_SAMPLE = RAM_WIDTH / 8;
   localparam int ADDR_W           = $clog2(RAM_DEPTH);
   localparam int CNT_W            = (BYTES_PER_SAMPLE > 1) ? $clog2(BYTES_PER_SAMPLE) : 1;
   // The shift register holds only the bytes that come before the final byte
   // of a group. The final byte goes straight into the write data.
   localparam int SHIFT_W          = (RAM_WIDTH > 8) ? RAM_WIDTH - 8 : 8;

   localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(BYTES_PER_SAMPLE - 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
`ifdef WAVETABLE_LOADER_CHECKSUM_EN
   localparam logic [1:0] ST_CHECK = 2'd2;
`endif

   logic [1:0]           state_reg,   state_next;
   logic [CNT_W-1:0]     cnt_reg,     cnt_next;
   logic [ADDR_W-1:0]    addr_reg,    addr_next;
   logic [SHIFT_W-1:0]   shift_reg,   shift_next;
   logic [ADDR_W-1:0]    wr_addr_reg, wr_addr_next;
   logic [RAM_WIDTH-1:0] wr_data_reg, wr_data_next;
   logic                 wr_en_reg,   wr_en_next;
   logic                 busy_reg,    busy_next;
   logic                 done_reg,    done_next;
`ifdef WAVETABLE_LOADER_CHECKSUM_EN
   logic [7:0]           xor_reg,     xor_next;
   logic                 error_reg,   error_next;
`endif

   logic                 accept;
   logic                 last_byte;
   logic                 last_addr;
   logic [RAM_WIDTH-1:0] packed_word;
   logic [SHIFT_W-1:0]   shift_in;

   // A byte is taken only when it is offered and the loader is listening.
   assign accept    = byte_valid_in && byte_ready_out;
   assign last_byte = (cnt_reg == LAST_CNT);
   assign last_addr = (addr_reg == LAST_ADDR);

   // Build the full sample and the shifted partial word. Narrow widths must not
   // slice below bit 0, so the structure depends on RAM_WIDTH.
   generate
      if (RAM_WIDTH >= 24) begin : g_wide
         assign packed_word = {shift_reg, byte_in};
         assign shift_in    = {shift_reg[SHIFT_W-9:0], byte_in};
      end else if (RAM_WIDTH == 16) begin : g_two_byte
         assign packed_word = {shift_reg, byte_in};
         assign shift_in    = byte_in;
      end else begin : g_one_byte
         assign packed_word = byte_in;
         assign shift_in    = byte_in;
      end
   endgenerate

   // Next-state and next-output logic for the IDLE/LOAD(/CHECK) sequencer.
   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      addr_next    = addr_reg;
      shift_next   = shift_reg;
      wr_addr_next = wr_addr_reg;
      wr_data_next = wr_data_reg;
      wr_en_next   = 1'b0;
      busy_next    = busy_reg;
      done_next    = 1'b0;
`ifdef WAVETABLE_LOADER_CHECKSUM_EN
      xor_next     = xor_reg;
      error_next   = error_reg;
`endif

      case (state_reg)
         ST_IDLE: begin
            // start_in beats a simultaneous abort_in, which has no meaning here.
            if (start_in) begin
               state_next = ST_LOAD;
               cnt_next   = '0;
               addr_next  = '0;
               shift_next = '0;
               busy_next  = 1'b1;
`ifdef WAVETABLE_LOADER_CHECKSUM_EN
               xor_next   = 8'h00;
               error_next = 1'b0;
`endif
            end
         end

         ST_LOAD: begin
            if (abort_in) begin
               // Drop the partial sample. Samples already written stay in RAM.
               state_next = ST_IDLE;
               cnt_next   = '0;
               shift_next = '0;
               busy_next  = 1'b0;
            end else if (accept) begin
`ifdef WAVETABLE_LOADER_CHECKSUM_EN
               xor_next = xor_reg ^ byte_in;
`endif
               if (last_byte) begin
                  wr_en_next   = 1'b1;
                  wr_addr_next = addr_reg;
                  wr_data_next = packed_word;
                  cnt_next     = '0;
                  shift_next   = '0;
                  if (last_addr) begin
                     // The table is full. The address stays at the final entry.
`ifdef WAVETABLE_LOADER_CHECKSUM_EN
                     state_next = ST_CHECK;
`else
                     state_next = ST_IDLE;
                     busy_next  = 1'b0;
                     done_next  = 1'b1;
`endif
                  end else begin
                     addr_next = addr_reg + 1'b1;
                  end
               end else begin
                  cnt_next   = cnt_reg + 1'b1;
                  shift_next = shift_in;
               end
            end
         end

`ifdef WAVETABLE_LOADER_CHECKSUM_EN
         ST_CHECK: begin
            if (abort_in) begin
               state_next = ST_IDLE;
               busy_next  = 1'b0;
            end else if (accept) begin
               // The trailing byte is the sender's XOR of the whole table.
               state_next = ST_IDLE;
               busy_next  = 1'b0;
               done_next  = 1'b1;
               error_next = (byte_in != xor_reg);
            end
         end
`endif

         default: begin
            state_next = ST_IDLE;
            busy_next  = 1'b0;
         end
      endcase
   end

   // State and output registers. Reset clears everything immediately.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_reg   <= ST_IDLE;
         cnt_reg     <= '0;
         addr_reg    <= '0;
         shift_reg   <= '0;
         wr_addr_reg <= '0;
         wr_data_reg <= '0;
         wr_en_reg   <= 1'b0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         addr_reg    <= addr_next;
         shift_reg   <= shift_next;
         wr_addr_reg <= wr_addr_next;
         wr_data_reg <= wr_data_next;
         wr_en_reg   <= wr_en_next;
         busy_reg    <= busy_next;
         done_reg    <= done_next;
      end
   end

`ifdef WAVETABLE_LOADER_CHECKSUM_EN
   // Checksum accumulator and the sticky mismatch flag.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         xor_reg   <= 8'h00;
         error_reg <= 1'b0;
      end else begin
         xor_reg   <= xor_next;
         error_reg <= error_next;
      end
   end

   assign error_out = error_reg;
`else
   assign error_out = 1'b0;
`endif

   // The loader never stalls while a load is active, so ready is decoded from the state.
   assign byte_ready_out = (state_reg != ST_IDLE);
   assign wr_addr_out    = wr_addr_reg;
   assign wr_data_out    = wr_data_reg;
   assign wr_en_out      = wr_en_reg;
   assign busy_out       = busy_reg;
   assign done_out       = done_reg;

endmodule

// File: tb/tb_wavetable_loader.sv
// Directed testbench for wavetable_loader with a write scoreboard.
// Each expected RAM write is pushed to a queue when its bytes are driven.
// A negedge monitor pops one entry for every wr_en_out pulse and compares it.
// Build with +define+WAVETABLE_LOADER_CHECKSUM_EN to cover the checksum stage.

module tb_wavetable_loader;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic        start_in = 1'b0;
   logic        abort_in = 1'b0;
   logic [7:0]  byte_in = 8'h00;
   logic        byte_valid_in = 1'b0;
   logic        byte_ready_out;
   logic [8:0]  wr_addr_out;
   logic [23:0] wr_data_out;
   logic        wr_en_out;
   logic        busy_out;
   logic        done_out;
   logic        error_out;

   wavetable_loader #(.RAM_WIDTH(24), .RAM_DEPTH(512)) dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .start_in      (start_in),
      .abort_in      (abort_in),
      .byte_in       (byte_in),
      .byte_valid_in (byte_valid_in),
      .byte_ready_out(byte_ready_out),
      .wr_addr_out   (wr_addr_out),
      .wr_data_out   (wr_data_out),
      .wr_en_out     (wr_en_out),
      .busy_out      (busy_out),
      .done_out      (done_out),
      .error_out     (error_out)
   );

   always #5 clk_in = ~clk_in;

   typedef struct packed {
      logic [8:0]  addr;
      logic [23:0] data;
   } wr_t;

   wr_t        exp_q[$];
   int         checks = 0;
   int         failures = 0;
   int         wr_cnt = 0;
   int         done_cnt = 0;
   logic [7:0] xor_acc = 8'h00;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard monitor: every write must match the oldest queued entry.
   always @(negedge clk_in) begin
      wr_t e;
      if (done_out === 1'b1) done_cnt++;
      if (wr_en_out === 1'b1) begin
         wr_cnt++;
         chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("wr_addr", 32'(wr_addr_out), 32'(e.addr));
            chk("wr_data", 32'(wr_data_out), 32'(e.data));
            $display("write addr=%0d data=0x%06h expected addr=%0d data=0x%06h",
                     wr_addr_out, wr_data_out, e.addr, e.data);
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk_in);
   endtask

   task automatic send_byte(input logic [7:0] b);
      byte_in = b;
      byte_valid_in = 1'b1;
      @(negedge clk_in);
      byte_valid_in = 1'b0;
   endtask

   task automatic send_sample(input logic [23:0] s, input bit gaps);
      logic [7:0] b;
      for (int i = 0; i < 3; i++) begin
         if (gaps && ($urandom_range(0, 3) == 0)) cyc(1);
         b = s[23 - 8*i -: 8];
         xor_acc = xor_acc ^ b;
         send_byte(b);
      end
   endtask

   task automatic push_exp(input int addr, input logic [23:0] data);
      wr_t e;
      e.addr = 9'(addr);
      e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic pulse_start();
      start_in = 1'b1;
      @(negedge clk_in);
      start_in = 1'b0;
      xor_acc = 8'h00;
   endtask

   task automatic pulse_abort();
      abort_in = 1'b1;
      @(negedge clk_in);
      abort_in = 1'b0;
   endtask

   function automatic logic [23:0] sample_k(input int k);
      logic [7:0] kb;
      kb = k[7:0];
      return {kb, 8'hA5, ~kb};
   endfunction

   task automatic full_load(input bit gaps);
      for (int k = 0; k < 512; k++) begin
         push_exp(k, sample_k(k));
         send_sample(sample_k(k), gaps);
      end
   endtask

   initial begin
      int w0;
      int d0;

      // Reset state
      cyc(2);
      chk("rst_wr_en", 32'(wr_en_out), 32'd0);
      chk("rst_busy", 32'(busy_out), 32'd0);
      chk("rst_ready", 32'(byte_ready_out), 32'd0);
      chk("rst_addr", 32'(wr_addr_out), 32'd0);
      chk("rst_data", 32'(wr_data_out), 32'd0);
      chk("rst_done", 32'(done_out), 32'd0);
      chk("rst_error", 32'(error_out), 32'd0);
      rst_in = 1'b0;
      cyc(2);
      chk("idle_ready", 32'(byte_ready_out), 32'd0);

      // Single sample: the write appears one cycle after the third byte
      pulse_start();
      chk("t1_busy", 32'(busy_out), 32'd1);
      chk("t1_ready", 32'(byte_ready_out), 32'd1);
      push_exp(0, 24'h123456);
      send_byte(8'h12);
      send_byte(8'h34);
      chk("t1_no_early_write", 32'(wr_en_out), 32'd0);
      send_byte(8'h56);
      chk("t1_wr_en", 32'(wr_en_out), 32'd1);
      chk("t1_addr", 32'(wr_addr_out), 32'd0);
      chk("t1_data", 32'(wr_data_out), 32'h123456);
      cyc(1);
      chk("t1_wr_en_one_cycle", 32'(wr_en_out), 32'd0);
      chk("t1_data_hold", 32'(wr_data_out), 32'h123456);
      pulse_abort();
      chk("t1_abort_busy", 32'(busy_out), 32'd0);

      // Full table load with random valid gaps
      w0 = wr_cnt;
      d0 = done_cnt;
      pulse_start();
      full_load(1'b1);
`ifdef WAVETABLE_LOADER_CHECKSUM_EN
      chk("t2_done_withheld", 32'(done_out), 32'd0);
      chk("t2_check_busy", 32'(busy_out), 32'd1);
      chk("t2_check_ready", 32'(byte_ready_out), 32'd1);
      send_byte(xor_acc);
      chk("t2_done", 32'(done_out), 32'd1);
      chk("t2_busy_drop", 32'(busy_out), 32'd0);
`else
      chk("t2_done", 32'(done_out), 32'd1);
      chk("t2_done_with_write", 32'(wr_en_out), 32'd1);
      chk("t2_busy_drop", 32'(busy_out), 32'd0);
`endif
      chk("t2_error", 32'(error_out), 32'd0);
      cyc(1);
      chk("t2_done_pulse", 32'(done_out), 32'd0);
      chk("t2_idle_busy", 32'(busy_out), 32'd0);
      chk("t2_idle_ready", 32'(byte_ready_out), 32'd0);
      chk("t2_last_addr_hold", 32'(wr_addr_out), 32'd511);
      chk("t2_write_count", 32'(wr_cnt - w0), 32'd512);
      chk("t2_done_count", 32'(done_cnt - d0), 32'd1);
      chk("t2_queue_empty", 32'(exp_q.size()), 32'd0);

`ifdef WAVETABLE_LOADER_CHECKSUM_EN
      // Bad checksum: error_out is set and held until the next start
      pulse_start();
      full_load(1'b0);
      send_byte(xor_acc ^ 8'h01);
      chk("t2e_done", 32'(done_out), 32'd1);
      chk("t2e_error", 32'(error_out), 32'd1);
      cyc(3);
      chk("t2e_error_sticky", 32'(error_out), 32'd1);
      pulse_start();
      chk("t2e_error_cleared", 32'(error_out), 32'd0);
      pulse_abort();
`endif

      // Abort after 4 bytes, then restart from an empty shift register
      w0 = wr_cnt;
      d0 = done_cnt;
      pulse_start();
      push_exp(0, 24'hC0FFEE);
      send_sample(24'hC0FFEE, 1'b0);
      send_byte(8'h77);
      pulse_abort();
      chk("t3_busy", 32'(busy_out), 32'd0);
      chk("t3_ready", 32'(byte_ready_out), 32'd0);
      cyc(2);
      chk("t3_write_count", 32'(wr_cnt - w0), 32'd1);
      chk("t3_no_done", 32'(done_cnt - d0), 32'd0);
      pulse_start();
      push_exp(0, 24'hAABBCC);
      send_sample(24'hAABBCC, 1'b0);
      cyc(1);
      chk("t3_restart_addr", 32'(wr_addr_out), 32'd0);
      chk("t3_queue_empty", 32'(exp_q.size()), 32'd0);
      // abort_in on the same edge as the final byte of a sample wins
      w0 = wr_cnt;
      send_byte(8'h01);
      send_byte(8'h02);
      byte_in = 8'h03;
      byte_valid_in = 1'b1;
      abort_in = 1'b1;
      @(negedge clk_in);
      byte_valid_in = 1'b0;
      abort_in = 1'b0;
      chk("t3_abort_wins_wr", 32'(wr_en_out), 32'd0);
      chk("t3_abort_wins_busy", 32'(busy_out), 32'd0);
      chk("t3_abort_wins_done", 32'(done_out), 32'd0);
      cyc(1);
      chk("t3_abort_wins_count", 32'(wr_cnt - w0), 32'd0);

      // start_in and abort_in together in IDLE: start wins. A later start during the load is ignored.
      start_in = 1'b1;
      abort_in = 1'b1;
      @(negedge clk_in);
      start_in = 1'b0;
      abort_in = 1'b0;
      xor_acc = 8'h00;
      chk("t4_start_beats_abort", 32'(busy_out), 32'd1);
      for (int k = 0; k < 100; k++) begin
         push_exp(k, sample_k(k + 7));
         send_sample(sample_k(k + 7), 1'b1);
      end
      chk("t4_addr99", 32'(wr_addr_out), 32'd99);
      start_in = 1'b1;
      @(negedge clk_in);
      start_in = 1'b0;
      chk("t4_start_ignored_busy", 32'(busy_out), 32'd1);
      for (int k = 100; k < 103; k++) begin
         push_exp(k, sample_k(k * 3));
         send_sample(sample_k(k * 3), 1'b0);
      end
      cyc(1);
      chk("t4_addr102", 32'(wr_addr_out), 32'd102);
      chk("t4_queue_empty", 32'(exp_q.size()), 32'd0);
      pulse_abort();

      // Asynchronous reset between clock edges in the middle of a sample
      pulse_start();
      push_exp(0, 24'h5A5A5A);
      send_sample(24'h5A5A5A, 1'b0);
      push_exp(1, 24'hA1B2C3);
      send_sample(24'hA1B2C3, 1'b0);
      send_byte(8'h11);
      chk("t5_pre_addr", 32'(wr_addr_out), 32'd1);
      #2;
      rst_in = 1'b1;
      #1;
      chk("t5_async_addr", 32'(wr_addr_out), 32'd0);
      chk("t5_async_data", 32'(wr_data_out), 32'd0);
      chk("t5_async_busy", 32'(busy_out), 32'd0);
      chk("t5_async_ready", 32'(byte_ready_out), 32'd0);
      chk("t5_async_wr_en", 32'(wr_en_out), 32'd0);
      @(negedge clk_in);
      rst_in = 1'b0;
      byte_in = 8'h99;
      byte_valid_in = 1'b1;
      cyc(3);
      byte_valid_in = 1'b0;
      chk("t5_ready_held_low", 32'(byte_ready_out), 32'd0);
      chk("t5_still_idle", 32'(busy_out), 32'd0);
      pulse_start();
      chk("t5_ready_after_start", 32'(byte_ready_out), 32'd1);
      push_exp(0, 24'h010203);
      send_sample(24'h010203, 1'b0);
      cyc(1);
      pulse_abort();
      chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wavetable_loader.md
Name: wavetable_loader

Overview:
- Write-side counterpart to the waveform playback oscillator.
- Accepts a byte stream (from the UART/host path) with a valid/ready handshake.
- Packs each group of bytes, MSB first, into one RAM_WIDTH-bit sample.
- Drives the write port (port A) of the 512-deep waveform RAM; the oscillator reads that RAM on port B.

Parameters:
- RAM_WIDTH, 24: sample width in bits; must be a multiple of 8.
- RAM_DEPTH, 512: number of samples per waveform. Address width is clog2(RAM_DEPTH).
- BYTES_PER_SAMPLE, RAM_WIDTH/8: bytes packed per sample. Derived; do not override.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous active-high reset
- start_in  input  1  one-cycle pulse; begins a full-table load at address 0
- abort_in  input  1  one-cycle pulse; cancels an in-progress load
- byte_in  input  8  stream data byte
- byte_valid_in  input  1  byte_in is valid
- byte_ready_out  output  1  loader can accept a byte this cycle
- wr_addr_out  output  clog2(RAM_DEPTH)  RAM port A address
- wr_data_out  output  RAM_WIDTH  RAM port A write data
- wr_en_out  output  1  RAM port A write enable (also drives ena)
- busy_out  output  1  a load is in progress
- done_out  output  1  one-cycle pulse when a load completes successfully
- error_out  output  1  checksum mismatch flag; sticky until next start

Behaviour:
- Reset (async, rst_in high) forces the following, held while rst_in is high:
  - state = IDLE
  - all outputs = 0
  - byte counter = 0, sample address = 0, shift register = 0
- States: IDLE, LOAD, CHECK (CHECK exists only with the optional feature).
- IDLE:
  - byte_ready_out = 0; incoming bytes are not consumed.
  - start_in moves to LOAD on the next edge: address = 0, byte counter = 0, error_out cleared, busy_out = 1.
- LOAD:
  - byte_ready_out = 1 continuously; the loader never stalls.
  - A byte is accepted only on an edge where byte_valid_in && byte_ready_out.
  - Accepted bytes shift into the low end of the shift register, so the first byte becomes bits [RAM_WIDTH-1:RAM_WIDTH-8].
- Write timing:
  - On the edge that accepts byte BYTES_PER_SAMPLE of a group, register wr_data_out = {previous bytes, byte_in}, wr_addr_out = current address, wr_en_out = 1.
  - The write is visible the cycle after the last byte is accepted. wr_en_out is high for exactly one cycle; the address increments on that same edge.
  - wr_data_out and wr_addr_out hold their values after the write until the next write.
- End of table:
  - The accepting edge for the last byte at address RAM_DEPTH-1 leaves LOAD.
  - Without the feature: go to IDLE, pulse done_out in the same cycle wr_en_out is high for the final write, busy_out drops in that cycle.
  - The address does not wrap past RAM_DEPTH-1 within a load.
- start_in while busy_out = 1 is ignored.
- abort_in in LOAD or CHECK:
  - Return to IDLE on the next edge; discard the partial sample; no done_out.
  - Samples already written stay in RAM.
  - abort_in wins over a simultaneous final-byte acceptance: no write, no done.
- abort_in in IDLE has no effect. Simultaneous start_in and abort_in in IDLE: start wins.
- Reset mid-load leaves RAM partially written. Higher-level control must hold the oscillator off (is_on_in low) until done_out.

Optional Feature:
- Macro: WAVETABLE_LOADER_CHECKSUM_EN.
- Enabled:
  - A running XOR of every accepted data byte is kept; it is cleared on start.
  - After the final write, enter CHECK with byte_ready_out = 1. busy_out stays high and done_out is withheld.
  - The next accepted byte is compared to the running XOR, then return to IDLE and pulse done_out.
  - error_out is set to 1 if the byte and the XOR differ, and stays set until the next start_in.
- Disabled:
  - No CHECK state and no XOR register.
  - error_out is tied to 0.
  - done_out pulses with the final write as described in Behaviour.

Test Plan:
- Reset, then pulse start_in and stream bytes 0x12,0x34,0x56 with valid held high:
  - wr_en_out is high for 1 cycle, wr_addr_out = 0, wr_data_out = 0x123456.
  - The write occurs 1 cycle after the third byte is accepted.
- Full load of 1536 bytes with sample k = {k[7:0], 0xA5, ~k[7:0]}, with valid randomly deasserted:
  - Exactly 512 writes at addresses 0..511 in order, with data matching.
  - done_out pulses once, then busy_out = 0 and byte_ready_out = 0.
- Pulse abort_in after 4 bytes:
  - Only address 0 is written; the loader is in IDLE with no done_out.
  - A following start_in restarts at address 0 with an empty shift register.
- Pulse start_in mid-load at address 100:
  - Ignored; addresses continue 100, 101, ...
- Assert rst_in asynchronously between clock edges mid-sample:
  - All outputs go to 0 immediately; byte_ready_out = 0 until the next start_in.
- With WAVETABLE_LOADER_CHECKSUM_EN defined:
  - Full load, then a correct XOR byte: done_out = 1, error_out = 0.
  - Repeat with XOR^0x01: done_out = 1, error_out = 1, and error_out is cleared by the next start_in.
